regfile_sequencer: RTL

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/regfile_sequencer.sv
// Five-state instruction sequencer driving an external register file.
// Define SHIFT_OPS_EN to make opcodes 8 (SHL) and 9 (SHR) legal.
module regfile_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] INSTR,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    output logic [2:0]  SA,
    output logic [2:0]  SB,
    output logic [2:0]  DR,
    output logic [7:0]  D_OUT,
    output logic        LD,
    input  logic [7:0]  DataA,
    input  logic [7:0]  DataB,
    output logic        DONE,
    output logic        FLAG_Z,
    output logic        FLAG_C,
    output logic        ERR
);

    typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WB} state_t;

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [2:0]  sa_q, sa_d, sb_q, sb_d, dr_q, dr_d;
    logic [7:0]  a_q, a_d, b_q, b_d, r_q, r_d;
    logic        ld_q, ld_d, done_q, done_d;
    logic        z_q, z_d, c_q, c_d, err_q, err_d;
    logic        zp_q, zp_d, cp_q, cp_d, bad_q, bad_d;
    logic        upd_z;
    logic [3:0]  opcode;
    logic [8:0]  sum_w, diff_w;

    assign opcode = instr_q[15:12];
    assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dr_d    = dr_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        ld_d    = 1'b0;
        done_d  = 1'b0;
        z_d     = z_q;
        c_d     = c_q;
        err_d   = err_q;
        zp_d    = zp_q;
        cp_d    = cp_q;
        bad_d   = bad_q;
        upd_z   = 1'b0;
        case (state_q)
            IDLE: begin
                if (INSTR_VALID) begin
                    instr_d = INSTR;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                dr_d    = instr_q[11:9];
                sa_d    = instr_q[8:6];
                sb_d    = instr_q[5:3];
                state_d = READ;
            end
            READ: begin
                a_d     = DataA;
                b_d     = DataB;
                state_d = EXEC;
            end
            EXEC: begin
                // Next flags are staged here and only committed on the WB edge.
                zp_d  = z_q;
                cp_d  = c_q;
                bad_d = 1'b0;
                case (opcode)
                    4'd0: ;
                    4'd1: begin r_d = sum_w[7:0];  cp_d = sum_w[8];  upd_z = 1'b1; end
                    4'd2: begin r_d = diff_w[7:0]; cp_d = diff_w[8]; upd_z = 1'b1; end
                    4'd3: begin r_d = a_q & b_q;   cp_d = 1'b0;      upd_z = 1'b1; end
                    4'd4: begin r_d = a_q | b_q;   cp_d = 1'b0;      upd_z = 1'b1; end
                    4'd5: begin r_d = a_q ^ b_q;   cp_d = 1'b0;      upd_z = 1'b1; end
                    4'd6: begin r_d = a_q;                           upd_z = 1'b1; end
                    4'd7: begin r_d = instr_q[7:0]; end
`ifdef SHIFT_OPS_EN
                    4'd8: begin r_d = {a_q[6:0], 1'b0}; cp_d = a_q[7]; upd_z = 1'b1; end
                    4'd9: begin r_d = {1'b0, a_q[7:1]}; cp_d = a_q[0]; upd_z = 1'b1; end
`endif
                    default: bad_d = 1'b1;
                endcase
                if (upd_z) zp_d = (r_d == 8'd0);
                ld_d    = (opcode != 4'd0) && !bad_d;
                done_d  = 1'b1;
                state_d = WB;
            end
            WB: begin
                z_d     = zp_q;
                c_d     = cp_q;
                err_d   = err_q | bad_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            instr_q <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            dr_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            ld_q    <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
            zp_q    <= 1'b0;
            cp_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dr_q    <= dr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            ld_q    <= ld_d;
            done_q  <= done_d;
            z_q     <= z_d;
            c_q     <= c_d;
            err_q   <= err_d;
            zp_q    <= zp_d;
            cp_q    <= cp_d;
            bad_q   <= bad_d;
        end
    end

    // An instruction offered while RESET is high must never be taken.
    assign INSTR_READY = (state_q == IDLE) && !RESET;
    assign SA     = sa_q;
    assign SB     = sb_q;
    assign DR     = dr_q;
    assign D_OUT  = r_q;
    assign LD     = ld_q;
    assign DONE   = done_q;
    assign FLAG_Z = z_q;
    assign FLAG_C = c_q;
    assign ERR    = err_q;

endmodule
